// File: rtl/butterfly2_pipe.sv
// Radix-2 DIT butterfly: out0 = a + W*b, out1 = a - W*b on one shared NxN multiplier.
// Define BUTTERFLY2_PIPE_SAT_EN to clamp out-of-range results instead of wrapping them.
module butterfly2_pipe #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_in0_re,
  input  logic [N-1:0] i_in0_im,
  input  logic [N-1:0] i_in1_re,
  input  logic [N-1:0] i_in1_im,
  input  logic [N-1:0] i_twiddle_re,
  input  logic [N-1:0] i_twiddle_im,
  input  logic         i_scale,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_out0_re,
  output logic [N-1:0] o_out0_im,
  output logic [N-1:0] o_out1_re,
  output logic [N-1:0] o_out1_im,
  output logic         o_ovf,
  output logic [1:0]   o_dbg_state
);

  localparam int AW = 2 * N + 1;
  localparam int SW = 2 * N + 2;
  localparam logic signed [SW-1:0] RND_HALF = SW'(1) << (Q - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never drops and data never changes until that transfer happens.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SUM  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [1:0] k_q, k_d;

  logic signed [N-1:0]  a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
  logic                 scale_q;
  logic signed [AW-1:0] acc_re_q, acc_im_q;
  logic [N-1:0]         out0_re_q, out0_im_q, out1_re_q, out1_im_q;
  logic                 ovf_q;

  logic signed [N-1:0]    mul_a, mul_b;
  logic signed [2*N-1:0]  prod;
  logic signed [AW-1:0]   prod_ext;

  logic signed [SW-1:0] rnd_re, rnd_im, t_re, t_im, a_re_x, a_im_x;
  logic signed [SW-1:0] s0_re, s0_im, s1_re, s1_im;
  logic signed [SW-1:0] c0_re, c0_im, c1_re, c1_im;
  logic                 sum_ovf;

  function automatic logic fits_n(input logic signed [SW-1:0] v);
    return (v[SW-1:N-1] == {(SW-N+1){v[N-1]}});
  endfunction

  function automatic logic [N-1:0] reduce_n(input logic signed [SW-1:0] v);
    logic [N-1:0] r;
    r = v[N-1:0];
`ifdef BUTTERFLY2_PIPE_SAT_EN
    if (!fits_n(v)) begin
      r = v[SW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: if (i_valid) begin
        state_d = S_MUL;
        k_d     = 2'd0;
      end
      S_MUL: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_SUM;
      end
      S_SUM:   state_d = S_OUT;
      S_OUT:   if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One product per MUL cycle: br*wr, bi*wi, br*wi, bi*wr.
  always_comb begin
    mul_a = b_re_q;
    mul_b = w_re_q;
    case (k_q)
      2'd1:    begin mul_a = b_im_q; mul_b = w_im_q; end
      2'd2:    begin mul_a = b_re_q; mul_b = w_im_q; end
      2'd3:    begin mul_a = b_im_q; mul_b = w_re_q; end
      default: begin mul_a = b_re_q; mul_b = w_re_q; end
    endcase
    prod     = $signed({{N{mul_a[N-1]}}, mul_a} * {{N{mul_b[N-1]}}, mul_b});
    prod_ext = {prod[2*N-1], prod};
  end

  always_comb begin
    rnd_re  = {acc_re_q[AW-1], acc_re_q} + RND_HALF;
    rnd_im  = {acc_im_q[AW-1], acc_im_q} + RND_HALF;
    t_re    = rnd_re >>> Q;
    t_im    = rnd_im >>> Q;
    a_re_x  = {{(SW-N){a_re_q[N-1]}}, a_re_q};
    a_im_x  = {{(SW-N){a_im_q[N-1]}}, a_im_q};
    s0_re   = a_re_x + t_re;
    s0_im   = a_im_x + t_im;
    s1_re   = a_re_x - t_re;
    s1_im   = a_im_x - t_im;
    c0_re   = scale_q ? (s0_re >>> 1) : s0_re;
    c0_im   = scale_q ? (s0_im >>> 1) : s0_im;
    c1_re   = scale_q ? (s1_re >>> 1) : s1_re;
    c1_im   = scale_q ? (s1_im >>> 1) : s1_im;
    sum_ovf = !(fits_n(c0_re) && fits_n(c0_im) && fits_n(c1_re) && fits_n(c1_im));
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      k_q       <= 2'd0;
      a_re_q    <= '0;
      a_im_q    <= '0;
      b_re_q    <= '0;
      b_im_q    <= '0;
      w_re_q    <= '0;
      w_im_q    <= '0;
      scale_q   <= 1'b0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      out0_re_q <= '0;
      out0_im_q <= '0;
      out1_re_q <= '0;
      out1_im_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      case (state_q)
        S_IDLE: if (i_valid) begin
          a_re_q  <= i_in0_re;
          a_im_q  <= i_in0_im;
          b_re_q  <= i_in1_re;
          b_im_q  <= i_in1_im;
          w_re_q  <= i_twiddle_re;
          w_im_q  <= i_twiddle_im;
          scale_q <= i_scale;
        end
        S_MUL: begin
          case (k_q)
            2'd0:    acc_re_q <= prod_ext;
            2'd1:    acc_re_q <= acc_re_q - prod_ext;
            2'd2:    acc_im_q <= prod_ext;
            default: acc_im_q <= acc_im_q + prod_ext;
          endcase
        end
        S_SUM: begin
          out0_re_q <= reduce_n(c0_re);
          out0_im_q <= reduce_n(c0_im);
          out1_re_q <= reduce_n(c1_re);
          out1_im_q <= reduce_n(c1_im);
          ovf_q     <= sum_ovf;
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_valid     = (state_q == S_OUT);
  assign o_out0_re   = out0_re_q;
  assign o_out0_im   = out0_im_q;
  assign o_out1_re   = out1_re_q;
  assign o_out1_im   = out1_im_q;
  assign o_ovf       = ovf_q;
  assign o_dbg_state = state_q;

endmodule
